// File: rtl/cr_huf_comp_sim_size_est.sv
// Compressed-size estimator for the huffman compressor.
// Each lane's symbol is looked up in a programmable range->bit-length profile.
// The lane products bl*cnt are summed into a saturating per-frame accumulator.
// The estimate is held on a valid/ready port, and input stalls until it is taken.
// Pipeline: P1 registers the accepted beat, P2 registers lane products, P3 accumulates.

`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 6
`endif

module cr_huf_comp_sim_size_est #(
    parameter int unsigned NUM_IN_SYMBOLS   = 4,
    parameter int unsigned DAT_WIDTH        = 10,
    parameter int unsigned CNT_WIDTH        = 3,
    parameter int unsigned NUM_RANGES       = 4,
    parameter int unsigned NUM_PROF         = 5,
    parameter int unsigned SIZE_WIDTH       = 20,
    parameter int unsigned MAX_NUM_SYM_USED = 576,
    // e_pipe_eob encoding width and its MIDDLE code
    parameter int unsigned EOB_WIDTH        = 3,
    parameter logic [EOB_WIDTH-1:0] EOB_MIDDLE = '0
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_IN_SYMBOLS-1:0]             sc_is_vld,
    input  logic [NUM_IN_SYMBOLS*DAT_WIDTH-1:0]   sc_is_sym,
    input  logic [NUM_IN_SYMBOLS*CNT_WIDTH-1:0]   sc_is_cnt,
    input  logic [`CREOLE_HC_SEQID_WIDTH-1:0]     sc_is_seq_id,
    input  logic [EOB_WIDTH-1:0]                  sc_is_eob,
    input  logic [$clog2(NUM_PROF)-1:0]           prof_sel,
    input  logic [NUM_PROF*NUM_RANGES*10-1:0]     cfg_range_sym,
    input  logic [NUM_PROF*NUM_RANGES*4-1:0]      cfg_range_bl,
    output logic                                  is_sc_rd,
    output logic                                  est_vld,
    input  logic                                  est_rdy,
    output logic [SIZE_WIDTH-1:0]                 est_size,
    output logic [`CREOLE_HC_SEQID_WIDTH-1:0]     est_seq_id,
    output logic [EOB_WIDTH-1:0]                  est_eob,
    output logic                                  est_ovf,
    output logic                                  est_bad_sym
);

    localparam int unsigned PROF_W = $clog2(NUM_PROF);
    localparam int unsigned PROD_W = 4 + CNT_WIDTH;
    localparam int unsigned SUM_W  = PROD_W + $clog2(NUM_IN_SYMBOLS) + 1;
    localparam int unsigned ADD_W  = ((SIZE_WIDTH > SUM_W) ? SIZE_WIDTH : SUM_W) + 1;

    localparam logic [PROF_W-1:0] LAST_PROF = PROF_W'(NUM_PROF - 1);
    localparam logic [10:0]       MAX_SYM   = 11'(MAX_NUM_SYM_USED);
    localparam logic [ADD_W-1:0]  SAT_VAL   = {{(ADD_W - SIZE_WIDTH){1'b0}}, {SIZE_WIDTH{1'b1}}};

    typedef enum logic [1:0] {StIdle, StAccum, StDrain, StOut} state_e;

    state_e                              state_q;
    logic                                drain_q;
    logic [`CREOLE_HC_SEQID_WIDTH-1:0]   seq_q;
    logic [EOB_WIDTH-1:0]                eob_q;
    logic [PROF_W-1:0]                   prof_q;

    logic                                accept;
    logic                                handshake;

    logic [NUM_IN_SYMBOLS-1:0]           p1_vld;
    logic [NUM_IN_SYMBOLS*DAT_WIDTH-1:0] p1_sym;
    logic [NUM_IN_SYMBOLS*CNT_WIDTH-1:0] p1_cnt;
    logic [PROF_W-1:0]                   p1_prof;

    logic [PROD_W-1:0]                   lane_prod [NUM_IN_SYMBOLS];
    logic [NUM_IN_SYMBOLS-1:0]           lane_bad;
    logic [PROD_W-1:0]                   p2_prod   [NUM_IN_SYMBOLS];
    logic [NUM_IN_SYMBOLS-1:0]           p2_bad;

    logic [SUM_W-1:0]                    lane_sum;
    logic [ADD_W-1:0]                    acc_sum;
    logic [SIZE_WIDTH-1:0]               acc_q;
    logic                                ovf_q;
    logic                                bad_q;

    assign is_sc_rd  = (state_q == StIdle) || (state_q == StAccum);
    assign accept    = is_sc_rd && (|sc_is_vld);
    assign handshake = est_vld && est_rdy;

    assign est_size    = acc_q;
    assign est_seq_id  = seq_q;
    assign est_eob     = eob_q;
    assign est_ovf     = ovf_q;
    assign est_bad_sym = bad_q;

    // Frame FSM: latch frame attributes, wait out the pipeline, then hold the estimate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            drain_q <= 1'b0;
            est_vld <= 1'b0;
            seq_q   <= '0;
            eob_q   <= EOB_MIDDLE;
            prof_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        seq_q  <= sc_is_seq_id;
                        prof_q <= prof_sel;
                        if (sc_is_eob != EOB_MIDDLE) begin
                            eob_q   <= sc_is_eob;
                            drain_q <= 1'b0;
                            state_q <= StDrain;
                        end else begin
                            state_q <= StAccum;
                        end
                    end
                end
                StAccum: begin
                    if (accept && (sc_is_eob != EOB_MIDDLE)) begin
                        eob_q   <= sc_is_eob;
                        drain_q <= 1'b0;
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    // Two cycles cover the P1->P2->P3 latency of the final beat.
                    if (drain_q) begin
                        est_vld <= 1'b1;
                        state_q <= StOut;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                StOut: begin
                    if (est_rdy) begin
                        est_vld <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // P1: register accepted beats; lanes of non-accepted cycles are forced invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_vld  <= '0;
            p1_sym  <= '0;
            p1_cnt  <= '0;
            p1_prof <= '0;
        end else begin
            p1_vld  <= accept ? sc_is_vld : '0;
            p1_sym  <= sc_is_sym;
            p1_cnt  <= sc_is_cnt;
            // First beat of a frame uses the live select, later beats the latched one.
            p1_prof <= (state_q == StIdle) ? prof_sel : prof_q;
        end
    end

    // P2 lookup: lowest matching range gives the bit length; misses flag a bad symbol.
    always_comb begin : p2_lookup
        logic [9:0]           sym;
        logic [CNT_WIDTH-1:0] cnt;
        logic [3:0]           bl;
        logic                 hit;
        logic                 illegal;
        int unsigned          prof_idx;
        int unsigned          base;
        sym      = '0;
        cnt      = '0;
        bl       = '0;
        hit      = 1'b0;
        illegal  = 1'b0;
        base     = 0;
        // An unimplemented select value falls back to profile 0.
        prof_idx = (p1_prof <= LAST_PROF) ? int'(p1_prof) : 0;
        lane_bad = '0;
        for (int l = 0; l < NUM_IN_SYMBOLS; l++) begin
            sym     = 10'(p1_sym[l*DAT_WIDTH +: DAT_WIDTH]);
            cnt     = p1_cnt[l*CNT_WIDTH +: CNT_WIDTH];
            illegal = ({1'b0, sym} >= MAX_SYM);
            hit     = 1'b0;
            bl      = '0;
            for (int unsigned r = 0; r < NUM_RANGES; r++) begin
                base = prof_idx * NUM_RANGES + r;
                if (!hit && (sym <= cfg_range_sym[base*10 +: 10])) begin
                    hit = 1'b1;
                    bl  = cfg_range_bl[base*4 +: 4];
                end
            end
            lane_prod[l] = '0;
            if (p1_vld[l] && (cnt != '0)) begin
                if (illegal || !hit) begin
                    lane_bad[l] = 1'b1;
                end else begin
                    lane_prod[l] = PROD_W'(bl) * PROD_W'(cnt);
                end
            end
        end
    end

    // P2: register lane products and bad-symbol flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < NUM_IN_SYMBOLS; l++) begin
                p2_prod[l] <= '0;
            end
            p2_bad <= '0;
        end else begin
            for (int l = 0; l < NUM_IN_SYMBOLS; l++) begin
                p2_prod[l] <= lane_prod[l];
            end
            p2_bad <= lane_bad;
        end
    end

    // P3 sum: widened so the saturation test cannot wrap.
    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < NUM_IN_SYMBOLS; l++) begin
            lane_sum = lane_sum + SUM_W'(p2_prod[l]);
        end
        acc_sum = ADD_W'(acc_q) + ADD_W'(lane_sum);
    end

    // P3: saturating accumulate with sticky flags, cleared when the estimate is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            bad_q <= 1'b0;
        end else if (handshake) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            bad_q <= 1'b0;
        end else begin
            if (acc_sum > SAT_VAL) begin
                acc_q <= {SIZE_WIDTH{1'b1}};
                ovf_q <= 1'b1;
            end else begin
                acc_q <= acc_sum[SIZE_WIDTH-1:0];
            end
            if (|p2_bad) begin
                bad_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cr_huf_comp_sim_size_est.sv
// Directed bench for cr_huf_comp_sim_size_est: default build plus a SIZE_WIDTH=8 build
// sharing the same stimulus, checked with immediate assertions.

`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 6
`endif

module tb_cr_huf_comp_sim_size_est;

    localparam logic [2:0] MID  = 3'd0;
    localparam logic [2:0] LAST = 3'd1;

    logic        clk;
    logic        rst_n;
    logic [3:0]  sc_is_vld;
    logic [39:0] sc_is_sym;
    logic [11:0] sc_is_cnt;
    logic [`CREOLE_HC_SEQID_WIDTH-1:0] sc_is_seq_id;
    logic [2:0]  sc_is_eob;
    logic [2:0]  prof_sel;
    logic [199:0] cfg_range_sym;
    logic [79:0]  cfg_range_bl;
    logic        est_rdy;

    logic        is_sc_rd;
    logic        est_vld;
    logic [19:0] est_size;
    logic [`CREOLE_HC_SEQID_WIDTH-1:0] est_seq_id;
    logic [2:0]  est_eob;
    logic        est_ovf;
    logic        est_bad_sym;

    logic        rd8;
    logic        vld8;
    logic [7:0]  size8;
    logic [`CREOLE_HC_SEQID_WIDTH-1:0] seq8;
    logic [2:0]  eob8;
    logic        ovf8;
    logic        bad8;

    int checks = 0;
    int errors = 0;

    cr_huf_comp_sim_size_est dut (
        .clk(clk), .rst_n(rst_n), .sc_is_vld(sc_is_vld), .sc_is_sym(sc_is_sym),
        .sc_is_cnt(sc_is_cnt), .sc_is_seq_id(sc_is_seq_id), .sc_is_eob(sc_is_eob),
        .prof_sel(prof_sel), .cfg_range_sym(cfg_range_sym), .cfg_range_bl(cfg_range_bl),
        .is_sc_rd(is_sc_rd), .est_vld(est_vld), .est_rdy(est_rdy), .est_size(est_size),
        .est_seq_id(est_seq_id), .est_eob(est_eob), .est_ovf(est_ovf),
        .est_bad_sym(est_bad_sym)
    );

    cr_huf_comp_sim_size_est #(.SIZE_WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .sc_is_vld(sc_is_vld), .sc_is_sym(sc_is_sym),
        .sc_is_cnt(sc_is_cnt), .sc_is_seq_id(sc_is_seq_id), .sc_is_eob(sc_is_eob),
        .prof_sel(prof_sel), .cfg_range_sym(cfg_range_sym), .cfg_range_bl(cfg_range_bl),
        .is_sc_rd(rd8), .est_vld(vld8), .est_rdy(est_rdy), .est_size(size8),
        .est_seq_id(seq8), .est_eob(eob8), .est_ovf(ovf8), .est_bad_sym(bad8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat; it is accepted on the following edge.
    task automatic beat(input string tag, input logic [3:0] v, input logic [39:0] s,
                        input logic [11:0] c, input logic [2:0] e,
                        input logic [`CREOLE_HC_SEQID_WIDTH-1:0] q, input logic [2:0] p);
        chk({tag, "_rd"}, 32'(is_sc_rd), 32'd1);
        sc_is_vld    = v;
        sc_is_sym    = s;
        sc_is_cnt    = c;
        sc_is_eob    = e;
        sc_is_seq_id = q;
        prof_sel     = p;
        step();
        sc_is_vld = '0;
    endtask

    // Called in cycle T+1 after the final beat; leaves the bench in cycle T+3.
    task automatic check_est(input string tag, input logic [19:0] size,
                             input logic [`CREOLE_HC_SEQID_WIDTH-1:0] q, input logic [2:0] e,
                             input logic ovf, input logic bad);
        chk({tag, "_vld_t1"}, 32'(est_vld), 32'd0);
        chk({tag, "_rd_t1"}, 32'(is_sc_rd), 32'd0);
        step();
        chk({tag, "_vld_t2"}, 32'(est_vld), 32'd0);
        step();
        chk({tag, "_vld_t3"}, 32'(est_vld), 32'd1);
        chk({tag, "_size"}, 32'(est_size), 32'(size));
        chk({tag, "_seq"}, 32'(est_seq_id), 32'(q));
        chk({tag, "_eob"}, 32'(est_eob), 32'(e));
        chk({tag, "_ovf"}, 32'(est_ovf), 32'(ovf));
        chk({tag, "_bad"}, 32'(est_bad_sym), 32'(bad));
    endtask

    task automatic finish_frame(input string tag);
        est_rdy = 1'b1;
        step();
        est_rdy = 1'b0;
        chk({tag, "_hs_vld"}, 32'(est_vld), 32'd0);
        chk({tag, "_hs_rd"}, 32'(is_sc_rd), 32'd1);
        chk({tag, "_hs_size"}, 32'(est_size), 32'd0);
        chk({tag, "_hs_ovf"}, 32'(est_ovf), 32'd0);
        chk({tag, "_hs_bad"}, 32'(est_bad_sym), 32'd0);
    endtask

    initial begin
        logic [9:0] bnd0 [4];
        logic [3:0] bl0  [4];
        logic [39:0] s_t1;
        logic [11:0] c_t1;
        bnd0 = '{10'd143, 10'd255, 10'd279, 10'd575};
        bl0  = '{4'd8, 4'd9, 4'd7, 4'd8};
        s_t1 = {10'd300, 10'd260, 10'd200, 10'd0};
        c_t1 = {3'd4, 3'd3, 3'd2, 3'd1};
        // Profile 1 maps every legal symbol to 2 bits; the rest copy profile 0.
        for (int p = 0; p < 5; p++) begin
            for (int r = 0; r < 4; r++) begin
                cfg_range_sym[(p*4+r)*10 +: 10] = (p == 1) ? 10'd575 : bnd0[r];
                cfg_range_bl[(p*4+r)*4 +: 4]    = (p == 1) ? 4'd2 : bl0[r];
            end
        end
        rst_n = 1'b0; est_rdy = 1'b0; sc_is_vld = '0; sc_is_sym = '0; sc_is_cnt = '0;
        sc_is_seq_id = '0; sc_is_eob = MID; prof_sel = '0;
        step();
        step();
        chk("rst_rd", 32'(is_sc_rd), 32'd1);
        chk("rst_vld", 32'(est_vld), 32'd0);
        chk("rst_size", 32'(est_size), 32'd0);
        chk("rst_seq", 32'(est_seq_id), 32'd0);
        chk("rst_eob", 32'(est_eob), 32'd0);
        chk("rst_ovf", 32'(est_ovf), 32'd0);
        chk("rst_bad", 32'(est_bad_sym), 32'd0);
        rst_n = 1'b1;
        step();

        // Single beat: 8*1 + 9*2 + 7*3 + 8*4 = 79.
        beat("t1", 4'hF, s_t1, c_t1, LAST, 6'd3, 3'd0);
        check_est("t1", 20'd79, 6'd3, LAST, 1'b0, 1'b0);
        finish_frame("t1");

        // Four beats of 4 lanes * (8*7) = 896; seq id from the first beat.
        beat("t2a", 4'hF, {4{10'd10}}, {4{3'd7}}, MID, 6'd7, 3'd0);
        beat("t2b", 4'hF, {4{10'd10}}, {4{3'd7}}, MID, 6'd9, 3'd0);
        beat("t2c", 4'hF, {4{10'd10}}, {4{3'd7}}, MID, 6'd9, 3'd0);
        beat("t2d", 4'hF, {4{10'd10}}, {4{3'd7}}, 3'd5, 6'd9, 3'd0);
        check_est("t2", 20'd896, 6'd7, 3'd5, 1'b0, 1'b0);

        // Stall with a beat pending at the input; it must neither be taken nor disturb est_*.
        sc_is_vld = 4'hF;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t3_stall_rd", 32'(is_sc_rd), 32'd0);
            chk("t3_stall_vld", 32'(est_vld), 32'd1);
            chk("t3_stall_size", 32'(est_size), 32'd896);
            chk("t3_stall_seq", 32'(est_seq_id), 32'd7);
            chk("t3_stall_eob", 32'(est_eob), 32'd5);
        end
        sc_is_vld = '0;
        finish_frame("t3");
        beat("t3n", 4'hF, s_t1, c_t1, LAST, 6'd4, 3'd0);
        check_est("t3n", 20'd79, 6'd4, LAST, 1'b0, 1'b0);
        finish_frame("t3n");

        // Profile selected on the first beat holds for the frame: 8 + 8 = 16.
        beat("pf_a", 4'hF, {4{10'd10}}, {4{3'd1}}, MID, 6'd11, 3'd1);
        beat("pf_b", 4'hF, {4{10'd10}}, {4{3'd1}}, LAST, 6'd12, 3'd0);
        check_est("pf", 20'd16, 6'd11, LAST, 1'b0, 1'b0);
        finish_frame("pf");

        // All-zero-count beat still opens the frame.
        beat("z_a", 4'hF, {4{10'd10}}, 12'd0, MID, 6'd2, 3'd0);
        beat("z_b", 4'hF, s_t1, c_t1, LAST, 6'd13, 3'd0);
        check_est("zc", 20'd79, 6'd2, LAST, 1'b0, 1'b0);
        finish_frame("zc");

        // Lane 0 symbol 600 is illegal: contributes 0; others 3 * 8 = 24.
        beat("bad", 4'hF, {10'd10, 10'd10, 10'd10, 10'd600}, {3'd1, 3'd1, 3'd1, 3'd5},
             LAST, 6'd20, 3'd0);
        check_est("bad", 20'd24, 6'd20, LAST, 1'b0, 1'b1);
        finish_frame("bad");

        // Two beats of 4 * 56 = 448; the 8-bit build saturates at 255.
        beat("ov_a", 4'hF, 40'd0, {4{3'd7}}, MID, 6'd21, 3'd0);
        beat("ov_b", 4'hF, 40'd0, {4{3'd7}}, LAST, 6'd21, 3'd0);
        check_est("ov", 20'd448, 6'd21, LAST, 1'b0, 1'b0);
        chk("ov8_vld", 32'(vld8), 32'd1);
        chk("ov8_size", 32'(size8), 32'd255);
        chk("ov8_ovf", 32'(ovf8), 32'd1);
        finish_frame("ov");
        chk("ov8_hs_ovf", 32'(ovf8), 32'd0);
        chk("ov8_hs_size", 32'(size8), 32'd0);

        // Reset while a beat sits in the pipeline; the partial frame is discarded.
        beat("rs_a", 4'hF, {4{10'd10}}, {4{3'd7}}, MID, 6'd5, 3'd0);
        rst_n = 1'b0;
        step();
        chk("rs_rd", 32'(is_sc_rd), 32'd1);
        chk("rs_vld", 32'(est_vld), 32'd0);
        chk("rs_size", 32'(est_size), 32'd0);
        step();
        chk("rs_size2", 32'(est_size), 32'd0);
        rst_n = 1'b1;
        step();
        beat("rs_b", 4'hF, s_t1, c_t1, LAST, 6'd6, 3'd0);
        check_est("rs", 20'd79, 6'd6, LAST, 1'b0, 1'b0);
        chk("rs8_size", 32'(size8), 32'd79);
        finish_frame("rs");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
